// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for an 8 x 16 register file: zero-fills all registers after
// reset or on request, then grants CPU (A) and debug (B) writes round-robin.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [2:0]  a_dr,
  input  logic [15:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [2:0]  b_dr,
  input  logic [15:0] b_data,
  output logic        b_ack,
  input  logic        init_start,
  output logic        busy,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_buss
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_dr_q, rf_dr_d;
  logic [15:0] rf_buss_q, rf_buss_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        busy_q, busy_d;

  logic a_elig, b_elig;
  logic grant_a, grant_b;

  // A requester whose ack is showing this cycle is still holding req from the
  // write just issued, so it must not be granted a second time.
  assign a_elig  = a_req && !a_ack_q;
  assign b_elig  = b_req && !b_ack_q;
  assign grant_a = a_elig && (!b_elig || last_grant_q);
  assign grant_b = b_elig && (!a_elig || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_dr_d      = rf_dr_q;
    rf_buss_d    = rf_buss_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;

    case (state_q)
      ST_INIT: begin
        rf_we_d   = 1'b1;
        rf_dr_d   = cnt_q;
        rf_buss_d = 16'h0000;
        if (cnt_q == 3'd7) begin
          state_d = ST_ARB;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ARB: begin
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = 3'd0;
        end else if (grant_a) begin
          rf_we_d      = 1'b1;
          rf_dr_d      = a_dr;
          rf_buss_d    = a_data;
          a_ack_d      = 1'b1;
          last_grant_d = 1'b0;
        end else if (grant_b) begin
          rf_we_d      = 1'b1;
          rf_dr_d      = b_dr;
          rf_buss_d    = b_data;
          b_ack_d      = 1'b1;
          last_grant_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 3'd0;
      end
    endcase

    // Covers the idle cycle right after an init request as well as the final
    // R7 write, which is issued while the state already points at ARB.
    busy_d = (state_q == ST_INIT) || (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_dr_q      <= 3'd0;
      rf_buss_q    <= 16'h0000;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_dr_q      <= rf_dr_d;
      rf_buss_q    <= rf_buss_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign busy    = busy_q;
  assign rf_we   = rf_we_q;
  assign rf_dr   = rf_dr_q;
  assign rf_buss = rf_buss_q;

`ifndef SYNTHESIS
  ack_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(a_ack_q && b_ack_q));
  ack_has_we: assert property (@(posedge clk) disable iff (!reset)
    (a_ack_q || b_ack_q) |-> rf_we_q);
  we_has_src: assert property (@(posedge clk) disable iff (!reset)
    (rf_we_q && !busy_q) |-> (a_ack_q || b_ack_q));
  busy_no_ack: assert property (@(posedge clk) disable iff (!reset)
    busy_q |-> !(a_ack_q || b_ack_q));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: outputs are sampled on the falling
// edge and compared as one packed vector {busy, rf_we, a_ack, b_ack, rf_dr, rf_buss}.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, b_req, init_start;
  logic [2:0]  a_dr, b_dr;
  logic [15:0] a_data, b_data;
  logic        a_ack, b_ack, busy, rf_we;
  logic [2:0]  rf_dr;
  logic [15:0] rf_buss;

  int checks = 0;
  int passed = 0;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .a_dr       (a_dr),
    .a_data     (a_data),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_dr       (b_dr),
    .b_data     (b_data),
    .b_ack      (b_ack),
    .init_start (init_start),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_dr      (rf_dr),
    .rf_buss    (rf_buss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [22:0] obs;
  assign obs = {busy, rf_we, a_ack, b_ack, rf_dr, rf_buss};

  function automatic logic [22:0] pack_exp(input logic bz, input logic we,
                                           input logic aa, input logic ba,
                                           input logic [2:0] dr, input logic [15:0] d);
    return {bz, we, aa, ba, dr, d};
  endfunction

  task automatic test_reset();
    logic [22:0] e;
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0; init_start = 1'b0;
    a_dr = 3'd0; b_dr = 3'd0; a_data = 16'h0; b_data = 16'h0;
    #2 reset = 1'b0;
    #1;
    e = pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checks++;
    if (obs !== e) $display("FAIL reset_async: got %h expected %h", obs, e);
    else begin passed++; $display("ok   reset_async     %h", obs); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== e) $display("FAIL reset_held: got %h expected %h", obs, e);
    else begin passed++; $display("ok   reset_held      %h", obs); end
    reset = 1'b1;
  endtask

  task automatic test_init_sequence();
    logic [22:0] e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = pack_exp(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'h0);
      checks++;
      if (obs !== e) $display("FAIL init_write_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   init_write_%0d    %h", i, obs); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0);
      checks++;
      if (obs !== e) $display("FAIL init_done_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   init_done_%0d     %h", i, obs); end
    end
  endtask

  task automatic test_pending_through_init();
    logic [22:0] e;
    reset = 1'b0;
    a_req = 1'b1; a_dr = 3'd3; a_data = 16'h1234;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = pack_exp(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'h0);
      checks++;
      if (obs !== e) $display("FAIL pend_init_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   pend_init_%0d     %h", i, obs); end
    end
    @(negedge clk);
    e = pack_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234);
    checks++;
    if (obs !== e) $display("FAIL pend_grant: got %h expected %h", obs, e);
    else begin passed++; $display("ok   pend_grant      %h", obs); end
    a_req = 1'b0;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234);
    checks++;
    if (obs !== e) $display("FAIL pend_idle_hold: got %h expected %h", obs, e);
    else begin passed++; $display("ok   pend_idle_hold  %h", obs); end
  endtask

  task automatic test_round_robin();
    logic [22:0] e;
    logic [15:0] last;
    last = 16'h0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    a_dr = 3'd1; b_dr = 3'd2;
    a_data = 16'hA000; b_data = 16'hB000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if ((k % 2) == 0) begin
        e = pack_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, a_data);
        last = a_data;
        a_data = a_data + 16'd1;
      end else begin
        e = pack_exp(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, b_data);
        last = b_data;
        b_data = b_data + 16'd1;
      end
      checks++;
      if (obs !== e) $display("FAIL rr_grant_%0d: got %h expected %h", k, obs, e);
      else begin passed++; $display("ok   rr_grant_%0d      %h", k, obs); end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, last);
    checks++;
    if (obs !== e) $display("FAIL rr_idle: got %h expected %h", obs, e);
    else begin passed++; $display("ok   rr_idle         %h", obs); end
  endtask

  task automatic test_single_hold();
    logic [22:0] e;
    a_req = 1'b1; a_dr = 3'd5; a_data = 16'h5555;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h5555);
    checks++;
    if (obs !== e) $display("FAIL hold_ack: got %h expected %h", obs, e);
    else begin passed++; $display("ok   hold_ack        %h", obs); end
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5555);
    checks++;
    if (obs !== e) $display("FAIL hold_no_regrant: got %h expected %h", obs, e);
    else begin passed++; $display("ok   hold_no_regrant %h", obs); end
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== e) $display("FAIL hold_after: got %h expected %h", obs, e);
    else begin passed++; $display("ok   hold_after      %h", obs); end
    a_req = 1'b1; a_data = 16'h5AAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ((k % 2) == 0) e = pack_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h5AAA);
      else              e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5AAA);
      checks++;
      if (obs !== e) $display("FAIL solo_rate_%0d: got %h expected %h", k, obs, e);
      else begin passed++; $display("ok   solo_rate_%0d     %h", k, obs); end
    end
    a_req = 1'b0;
  endtask

  task automatic test_same_dr();
    logic [22:0] e;
    a_req = 1'b1; a_dr = 3'd6; a_data = 16'h1111;
    b_req = 1'b1; b_dr = 3'd6; b_data = 16'h2222;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 16'h2222);
    checks++;
    if (obs !== e) $display("FAIL samedr_first_b: got %h expected %h", obs, e);
    else begin passed++; $display("ok   samedr_first_b  %h", obs); end
    b_req = 1'b0;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 16'h1111);
    checks++;
    if (obs !== e) $display("FAIL samedr_then_a: got %h expected %h", obs, e);
    else begin passed++; $display("ok   samedr_then_a   %h", obs); end
    a_req = 1'b0;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h1111);
    checks++;
    if (obs !== e) $display("FAIL samedr_idle: got %h expected %h", obs, e);
    else begin passed++; $display("ok   samedr_idle     %h", obs); end
  endtask

  task automatic test_init_start();
    logic [22:0] e;
    init_start = 1'b1;
    b_req = 1'b1; b_dr = 3'd7; b_data = 16'hBEEF;
    @(negedge clk);
    e = pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 16'h1111);
    checks++;
    if (obs !== e) $display("FAIL istart_entry: got %h expected %h", obs, e);
    else begin passed++; $display("ok   istart_entry    %h", obs); end
    init_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = pack_exp(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'h0);
      checks++;
      if (obs !== e) $display("FAIL istart_write_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   istart_write_%0d  %h", i, obs); end
      init_start = (i == 3);
    end
    @(negedge clk);
    e = pack_exp(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 16'hBEEF);
    checks++;
    if (obs !== e) $display("FAIL istart_b_grant: got %h expected %h", obs, e);
    else begin passed++; $display("ok   istart_b_grant  %h", obs); end
    b_req = 1'b0;
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'hBEEF);
    checks++;
    if (obs !== e) $display("FAIL istart_idle: got %h expected %h", obs, e);
    else begin passed++; $display("ok   istart_idle     %h", obs); end
  endtask

  task automatic test_reset_mid_init();
    logic [22:0] e;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = pack_exp(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'h0);
      checks++;
      if (obs !== e) $display("FAIL mid_pre_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   mid_pre_%0d       %h", i, obs); end
    end
    #2 reset = 1'b0;
    #1;
    e = pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checks++;
    if (obs !== e) $display("FAIL mid_async_reset: got %h expected %h", obs, e);
    else begin passed++; $display("ok   mid_async_reset %h", obs); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = pack_exp(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'h0);
      checks++;
      if (obs !== e) $display("FAIL mid_restart_%0d: got %h expected %h", i, obs, e);
      else begin passed++; $display("ok   mid_restart_%0d   %h", i, obs); end
    end
    @(negedge clk);
    e = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0);
    checks++;
    if (obs !== e) $display("FAIL mid_done: got %h expected %h", obs, e);
    else begin passed++; $display("ok   mid_done        %h", obs); end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_pending_through_init();
    test_round_robin();
    test_single_hold();
    test_same_dr();
    test_init_start();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock port named clk, reset port named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset: 0 = in reset.
REQ-004 a_req  input  1  requester A (CPU writeback) write request; held high until a_ack.
REQ-005 a_dr  input  3  requester A destination register.
REQ-006 a_data  input  16  requester A write data.
REQ-007 a_ack  output  1  one-cycle pulse; A's write is issued this cycle.
REQ-008 b_req, b_dr, b_data, b_ack  same widths and meaning as the A ports, for requester B (debug/host).
REQ-009 init_start  input  1  level-sampled request to re-zero all eight registers.
REQ-010 busy  output  1  high while the init sequence owns the register-file write port.
REQ-011 rf_we  output  1  register-file write enable (drives regWE).
REQ-012 rf_dr  output  3  register-file destination select (drives DR).
REQ-013 rf_buss  output  16  register-file write data (drives Buss).

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 States SHALL be INIT and ARB; 3-bit init counter; 1-bit round-robin pointer (last_grant, 0=A, 1=B).
REQ-016 INIT: each cycle SHALL drive rf_we=1, rf_dr=counter, rf_buss=16'h0000; counter 0..7; exactly 8 writes; after counter=7 write, next state ARB with counter=0.
REQ-017 busy SHALL be 1 in every cycle where state is INIT (including reset) and 0 from the first ARB cycle.
REQ-018 In INIT, a_ack and b_ack SHALL stay 0; pending requests wait, are not dropped.
REQ-019 ARB: requester X eligible when x_req=1 and x_ack is not currently 1 (prevents double grant of held request).
REQ-020 ARB, one eligible: grant it. Both eligible: grant the one not equal to last_grant.
REQ-021 Grant at edge t SHALL produce in cycle t+1: rf_we=1, rf_dr/rf_buss = granted x_dr/x_data sampled at edge t, x_ack=1, other ack=0, last_grant updated.
REQ-022 ARB, none eligible: next cycle rf_we=0, both acks 0; rf_dr/rf_buss hold previous values.
REQ-023 At most one ack high per cycle; rf_we high exactly when an ack is high or in INIT.
REQ-024 Same-DR requests from A and B SHALL be serialized in round-robin order with no merging; last write wins in the register file.
REQ-025 init_start=1 sampled in ARB SHALL move to INIT at that edge with counter=0 and no grant at that edge; init_start in INIT is ignored (no restart).
REQ-026 Sustained A and B requests SHALL alternate, one write per cycle total; a single requester SHALL get at most one write per 2 cycles.

Reset
REQ-027 Reset asserted SHALL immediately force state=INIT, counter=0, last_grant=1 (A wins first tie), rf_we=0, rf_dr=0, rf_buss=0, a_ack=0, b_ack=0, busy=1.
REQ-028 First rising edge after reset deassertion SHALL produce the R0 zero write (rf_we=1, rf_dr=0); ARB begins 8 edges after deassertion.
REQ-029 Reset asserted mid-INIT or mid-grant SHALL abort immediately; the sequence restarts from R0 after deassertion; no ack is issued for the interrupted request.

Verification
REQ-030 Release reset, no requests -> rf_we=1 for 8 cycles with rf_dr 0..7, rf_buss=0, busy=1; then busy=0, rf_we=0.
REQ-031 a_req=1 (a_dr=3, a_data=16'h1234) held through INIT -> no ack during INIT; first ARB edge grants; next cycle rf_we=1, rf_dr=3, rf_buss=16'h1234, a_ack=1.
REQ-032 A and B both requesting continuously from idle ARB -> acks A,B,A,B... on consecutive cycles, matching dr/data each cycle.
REQ-033 A alone, req held high across its ack for one extra cycle -> exactly one a_ack, rf_we pulse of 1 cycle.
REQ-034 init_start=1 pulsed while b_req pending -> 8 zero writes, busy=1, then b granted on first ARB edge.
REQ-035 reset asserted during INIT cycle with rf_dr=4 -> outputs go to reset values asynchronously; after release, writes restart at rf_dr=0.
